// File: rtl/decode_queue.sv
// decode_queue: registered instruction-decode stage for the 9-bit RISC core.
// Raw instructions are decoded on FIFO write. The decoded bundles are held in
// a DEPTH-entry queue between fetch and register read/execute.
//
// Ports:
//   clk, reset              clock; synchronous active-high reset
//   in_valid/in_ready       fetch handshake (in_ready = !full)
//   in_instr[8:0]           raw instruction
//   flush                   discard queued and same-cycle incoming instructions
//   out_valid/out_ready     consumer handshake on the head bundle
//   out_ritype .. out_rt    decoded head fields, zero whenever out_valid=0
//   out_level               occupancy, 0..DEPTH
//
// Optional (define DECODE_QUEUE_STATS_EN):
//   stat_issued[15:0]       saturating count of pops
//   stat_flushed[15:0]      saturating count of entries discarded by flush
module decode_queue #(
    parameter int DATA_W = 8,
    parameter int MEM_AW = 8,
    parameter int PC_W   = 5,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [8:0]               in_instr,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_ritype,
    output logic [2:0]               out_rop,
    output logic [1:0]               out_iop,
    output logic [DATA_W-1:0]        out_imm,
    output logic [2:0]               out_immb,
    output logic [PC_W-1:0]          out_jaddr,
    output logic [MEM_AW-1:0]        out_memadd,
    output logic [DATA_W-1:0]        out_shamt,
    output logic                     out_shdir,
    output logic [2:0]               out_rs,
    output logic [2:0]               out_rt,
    output logic [$clog2(DEPTH):0]   out_level
`ifdef DECODE_QUEUE_STATS_EN
    ,
    output logic [15:0]              stat_issued,
    output logic [15:0]              stat_flushed
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic              ritype;
        logic [2:0]        rop;
        logic [1:0]        iop;
        logic [DATA_W-1:0] imm;
        logic [2:0]        immb;
        logic [PC_W-1:0]   jaddr;
        logic [MEM_AW-1:0] memadd;
        logic [DATA_W-1:0] shamt;
        logic              shdir;
        logic [2:0]        rs;
        logic [2:0]        rt;
    } bundle_t;

    bundle_t        mem [DEPTH];
    bundle_t        dec;
    bundle_t        head;
    logic [AW-1:0]  wptr, rptr;
    logic [LW-1:0]  level;
    logic           full, push, pop;

    // Decode: any field not used by the opcode stays zero.
    always_comb begin
        dec        = '0;
        dec.ritype = in_instr[8];
        if (!in_instr[8]) begin
            dec.rop = in_instr[7:5];
            case (in_instr[7:5])
                3'b100: begin  // MOV
                    dec.rs = {1'b0, in_instr[4:3]};
                    dec.rt = in_instr[2:0];
                end
                3'b101: begin  // shift
                    dec.rs    = in_instr[4:2];
                    dec.shamt = DATA_W'(in_instr[0]);
                    dec.shdir = in_instr[1];
                end
                3'b111: dec.jaddr = PC_W'(in_instr[4:0]);  // JMP
                default: begin
                    dec.rs = in_instr[4:2];
                    dec.rt = {1'b0, in_instr[1:0]};
                end
            endcase
        end else begin
            dec.iop = in_instr[7:6];
            case (in_instr[7:6])
                2'b00: begin  // BEQZ
                    dec.rs   = in_instr[5:3];
                    dec.immb = in_instr[2:0];
                end
                2'b01: begin  // LI
                    dec.rs  = in_instr[5:3];
                    dec.imm = DATA_W'(in_instr[2:0]);
                end
                default: begin  // LD / STR
                    dec.rs     = {2'b00, in_instr[5]};
                    dec.memadd = MEM_AW'(in_instr[4:0]);
                end
            endcase
        end
    end

    assign full      = (level == LW'(DEPTH));
    assign in_ready  = !full;
    assign out_valid = (level != '0);
    // in_ready depends only on occupancy, so a pop never frees a slot
    // for a push in the same cycle; flush cancels both.
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    // Storage is not reset; reads are masked by out_valid instead.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= dec;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;  // power-of-2 depth wraps naturally
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign head       = out_valid ? mem[rptr] : '0;
    assign out_ritype = head.ritype;
    assign out_rop    = head.rop;
    assign out_iop    = head.iop;
    assign out_imm    = head.imm;
    assign out_immb   = head.immb;
    assign out_jaddr  = head.jaddr;
    assign out_memadd = head.memadd;
    assign out_shamt  = head.shamt;
    assign out_shdir  = head.shdir;
    assign out_rs     = head.rs;
    assign out_rt     = head.rt;
    assign out_level  = level;

`ifdef DECODE_QUEUE_STATS_EN
    logic [16:0] fsum;
    assign fsum = {1'b0, stat_flushed} + 17'(level);

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_issued  <= '0;
            stat_flushed <= '0;
        end else if (flush) begin
            stat_flushed <= fsum[16] ? 16'hFFFF : fsum[15:0];
        end else if (pop && stat_issued != 16'hFFFF) begin
            stat_issued <= stat_issued + 16'd1;
        end
    end
`endif

endmodule
